// File: rtl/sram_bus_target.sv
// Target side of the multiplexed cartridge SRAM bus: demuxes the two-phase ALE address,
// prefetches on the low-byte edge and performs at most one write per access.
module sram_bus_target #(
    parameter int ADDR_W     = 20,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_cen,
    input  logic              bus_rdn,
    input  logic              bus_wdn,
    input  logic              bus_oen,
    input  logic [1:0]        bus_ale,
    input  logic [3:0]        bus_adrh,
    input  logic [7:0]        bus_wd,
    output logic [7:0]        bus_rd,
    output logic              bus_rd_oe,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd,
    output logic              protocol_err
);

    typedef enum logic [1:0] {IDLE, HI, PREF, DATA} state_t;

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wd_q, mem_wd_d;
    logic [7:0]          rd_hold_q, rd_hold_d;
    logic                cap_q, cap_d;
    logic                wrote_q, wrote_d;
    logic                err_q, err_d;
    logic                viol;
    logic [19:0]         full_addr;

    assign full_addr = {bus_adrh, hi_q, bus_wd};

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        rd_hold_d  = cap_q ? mem_rd : rd_hold_q;
        cap_d      = 1'b0;
        wrote_d    = wrote_q;
        viol       = !bus_cen && !bus_rdn && !bus_wdn;
        case (state_q)
            IDLE: begin
                if (!bus_cen && bus_ale == 2'b10) begin
                    hi_d    = bus_wd;
                    state_d = HI;
                end else if (bus_ale[0]) begin
                    viol = 1'b1;
                end
            end
            HI: begin
                if (!bus_cen && !bus_wdn) viol = 1'b1;
                if (bus_cen) begin
                    state_d = IDLE;
                    wrote_d = 1'b0;
                end else if (bus_ale == 2'b01) begin
                    addr_d     = ADDR_W'(full_addr);
                    mem_addr_d = ADDR_W'(full_addr);
                    mem_en_d   = 1'b1;
                    state_d    = PREF;
                end else if (bus_ale == 2'b10) begin
                    hi_d = bus_wd;
                end else begin
                    viol    = 1'b1;
                    state_d = IDLE;
                end
            end
            PREF: begin
                // The memory answers the prefetch one edge later; forward it for that
                // cycle (the controller samples it) and capture it at the end.
                cap_d = 1'b1;
                if (!bus_cen && !bus_wdn) viol = 1'b1;
                if (bus_cen) begin
                    state_d = IDLE;
                    wrote_d = 1'b0;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_cen) begin
                    state_d = IDLE;
                    wrote_d = 1'b0;
                end else if (bus_ale == 2'b10) begin
                    hi_d    = bus_wd;
                    wrote_d = 1'b0;
                    state_d = HI;
                end else if (!bus_wdn && !wrote_q) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_wd_d   = bus_wd;
                    rd_hold_d  = bus_wd;
                    wrote_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = ERR_STICKY ? (err_q | viol) : viol;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            addr_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            rd_hold_q  <= '0;
            cap_q      <= 1'b0;
            wrote_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            rd_hold_q  <= rd_hold_d;
            cap_q      <= cap_d;
            wrote_q    <= wrote_d;
            err_q      <= err_d;
        end
    end

    assign bus_rd       = cap_q ? mem_rd : rd_hold_q;
    assign bus_rd_oe    = bus_oen & ~bus_cen;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wd       = mem_wd_q;
    assign protocol_err = err_q;

endmodule
